dmem_access_ctrl: RTL and testbench

//  Arbiter/sequencer in front of the 128x32 data memory. Shares it between the pipeline MEM stage (port A) and a debug/loader port (port B).

---
 rtl/dmem_access_ctrl.sv | 145 ++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// Arbiter/sequencer sharing the 128x32 data memory between the pipeline MEM
// stage (port A, priority) and a debug/loader port (port B). Writes are
// one-cycle dm_write pulses, each followed by a one-cycle recovery gap so the
// memory sees a fresh rising edge for every write.
module dmem_access_ctrl #(
    parameter int DEPTH    = 128,
    parameter int MAX_HOLD = 4
) (
    input  logic        clk,
    input  logic        rst,
    // port A: pipeline MEM stage
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_stall,
    // port B: debug/loader
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    // memory side
    output logic        dm_read,
    output logic        dm_write,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    // sticky error flag
    output logic        err_addr
);

    localparam int             CW       = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0]  HOLD_MAX = CW'(MAX_HOLD);
    localparam logic [31:0]    DEPTH_W  = 32'(DEPTH);

    typedef enum logic {IDLE, WR_REC} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  starve_q, starve_d;
    logic           rvalid_q, rvalid_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           err_q, err_d;

    logic a_req;
    logic b_sel;

    assign a_req = mem_read | mem_write;
    // B wins when A is idle, or when it has been starved for MAX_HOLD cycles
    assign b_sel = dbg_req && (!a_req || (starve_q == HOLD_MAX));

    assign dbg_rvalid = rvalid_q;
    assign dbg_rdata  = rdata_q;
    assign err_addr   = err_q;

    // State, starvation counter, registered B read return and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Arbitration, memory command generation and next-state logic
    always_comb begin
        state_d   = state_q;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        err_d     = err_q;
        dm_read   = 1'b0;
        dm_write  = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = '0;
        mem_stall = 1'b0;
        dbg_gnt   = 1'b0;

        case (state_q)
            WR_REC: begin
                // write recovery gap: memory idle, A held off
                mem_stall = a_req;
                state_d   = IDLE;
            end
            default: begin
                if (b_sel) begin
                    dbg_gnt   = 1'b1;
                    mem_stall = a_req;
                    if (dbg_addr >= DEPTH_W) begin
                        // out of range: consume the request, return zero on reads
                        err_d = 1'b1;
                        if (!dbg_we) begin
                            rvalid_d = 1'b1;
                            rdata_d  = '0;
                        end
                    end else if (dbg_we) begin
                        dm_write = 1'b1;
                        dm_addr  = dbg_addr;
                        dm_wdata = dbg_wdata;
                        state_d  = WR_REC;
                    end else begin
                        dm_read  = 1'b1;
                        dm_addr  = dbg_addr;
                        rvalid_d = 1'b1;
                        rdata_d  = dm_rdata;
                    end
                end else if (a_req) begin
                    if (mem_read && mem_write) begin
                        // conflicting request: dropped, flagged
                        err_d = 1'b1;
                    end else if (mem_addr >= DEPTH_W) begin
                        err_d = 1'b1;
                    end else if (mem_read) begin
                        dm_read   = 1'b1;
                        dm_addr   = mem_addr;
                        mem_rdata = dm_rdata;
                    end else begin
                        dm_write = 1'b1;
                        dm_addr  = mem_addr;
                        dm_wdata = mem_wdata;
                        state_d  = WR_REC;
                    end
                end
            end
        endcase

        // count cycles B waits; cleared by a grant or by B withdrawing
        if (dbg_req && !dbg_gnt)
            starve_d = (starve_q == HOLD_MAX) ? starve_q : starve_q + 1'b1;
        else
            starve_d = '0;
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a small clocked memory model.
module tb_dmem_access_ctrl;

    logic        clk, rst;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_stall;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        dm_read, dm_write;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        err_addr;

    int checks = 0;
    int fails  = 0;

    logic [31:0] tb_mem [0:127];

    dmem_access_ctrl #(.DEPTH(128), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .dbg_rdata(dbg_rdata), .dm_read(dm_read), .dm_write(dm_write),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .err_addr(err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model: combinational read, write captured once per strobe
    assign dm_rdata = (dm_addr < 32'd128) ? tb_mem[dm_addr[6:0]] : 32'd0;
    always @(posedge clk)
        if (dm_write && dm_addr < 32'd128) tb_mem[dm_addr[6:0]] <= dm_wdata;

    task automatic idle_inputs();
        mem_read = 0; mem_write = 0; mem_addr = 0; mem_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        @(negedge clk); #2;
        checks++; if ({dm_read, dm_write, dbg_gnt, dbg_rvalid, mem_stall, err_addr} !== 6'b0) begin
            fails++; $display("FAIL reset_ctrl got=%b exp=000000", {dm_read, dm_write, dbg_gnt, dbg_rvalid, mem_stall, err_addr}); end
        checks++; if (dbg_rdata !== 32'd0 || mem_rdata !== 32'd0) begin
            fails++; $display("FAIL reset_data got=%h/%h exp=0/0", dbg_rdata, mem_rdata); end
        @(negedge clk); rst = 0;
    endtask

    task automatic test_a_read();
        @(negedge clk); mem_read = 1; mem_addr = 4; #2;
        checks++; if (dm_read !== 1'b1 || mem_stall !== 1'b0) begin
            fails++; $display("FAIL a_read_ctrl got=%b%b exp=10", dm_read, mem_stall); end
        checks++; if (mem_rdata !== 32'h0000000C) begin
            fails++; $display("FAIL a_read_data got=%h exp=0000000c", mem_rdata); end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_back_to_back();
        @(negedge clk); mem_write = 1; mem_addr = 5; mem_wdata = 32'hAA; #2;
        checks++; if (dm_write !== 1'b1 || dm_addr !== 32'd5 || mem_stall !== 1'b0) begin
            fails++; $display("FAIL b2b_c0 got=%b/%0d/%b exp=1/5/0", dm_write, dm_addr, mem_stall); end
        @(negedge clk); mem_addr = 6; mem_wdata = 32'hBB; #2;
        checks++; if (dm_write !== 1'b0 || mem_stall !== 1'b1) begin
            fails++; $display("FAIL b2b_c1_gap got=%b/%b exp=0/1", dm_write, mem_stall); end
        @(negedge clk); #2;
        checks++; if (dm_write !== 1'b1 || dm_addr !== 32'd6 || dm_wdata !== 32'hBB || mem_stall !== 1'b0) begin
            fails++; $display("FAIL b2b_c2 got=%b/%0d/%h/%b exp=1/6/bb/0", dm_write, dm_addr, dm_wdata, mem_stall); end
        @(negedge clk); mem_write = 0; mem_read = 1; mem_addr = 5; #2;
        checks++; if (mem_stall !== 1'b1 || mem_rdata !== 32'd0 || dm_read !== 1'b0) begin
            fails++; $display("FAIL b2b_c3_rec got=%b/%h/%b exp=1/0/0", mem_stall, mem_rdata, dm_read); end
        @(negedge clk); #2;
        checks++; if (mem_rdata !== 32'hAA) begin
            fails++; $display("FAIL b2b_rd5 got=%h exp=000000aa", mem_rdata); end
        @(negedge clk); mem_addr = 6; #2;
        checks++; if (mem_rdata !== 32'hBB) begin
            fails++; $display("FAIL b2b_rd6 got=%h exp=000000bb", mem_rdata); end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_dbg_read();
        @(negedge clk); dbg_req = 1; dbg_we = 0; dbg_addr = 4; #2;
        checks++; if (dbg_gnt !== 1'b1 || dm_read !== 1'b1 || dbg_rvalid !== 1'b0) begin
            fails++; $display("FAIL dbg_rd_t got=%b%b%b exp=110", dbg_gnt, dm_read, dbg_rvalid); end
        @(negedge clk); dbg_req = 0; #2;
        checks++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'h0000000C || dbg_gnt !== 1'b0) begin
            fails++; $display("FAIL dbg_rd_t1 got=%b/%h/%b exp=1/0000000c/0", dbg_rvalid, dbg_rdata, dbg_gnt); end
        @(negedge clk); #2;
        checks++; if (dbg_rvalid !== 1'b0 || dbg_rdata !== 32'h0000000C) begin
            fails++; $display("FAIL dbg_rd_t2 got=%b/%h exp=0/0000000c", dbg_rvalid, dbg_rdata); end
    endtask

    task automatic test_starve();
        logic exp_g;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            mem_read = 1; mem_addr = 4; dbg_req = 1; dbg_we = 0; dbg_addr = 5;
            #2;
            exp_g = (c == 4 || c == 9);
            checks++; if (dbg_gnt !== exp_g || mem_stall !== exp_g) begin
                fails++; $display("FAIL starve_c%0d got=%b/%b exp=%b/%b", c, dbg_gnt, mem_stall, exp_g, exp_g); end
            if (c == 4) begin
                checks++; if (mem_rdata !== 32'd0 || dm_addr !== 32'd5) begin
                    fails++; $display("FAIL starve_c4_data got=%h/%0d exp=0/5", mem_rdata, dm_addr); end
            end
            if (c == 5) begin
                checks++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'hAA || mem_rdata !== 32'h0C) begin
                    fails++; $display("FAIL starve_c5_ret got=%b/%h/%h exp=1/aa/0c", dbg_rvalid, dbg_rdata, mem_rdata); end
            end
        end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_err();
        @(negedge clk); mem_write = 1; mem_addr = 200; mem_wdata = 32'h55; #2;
        checks++; if (dm_write !== 1'b0 || mem_stall !== 1'b0 || err_addr !== 1'b0) begin
            fails++; $display("FAIL err_oor got=%b/%b/%b exp=0/0/0", dm_write, mem_stall, err_addr); end
        @(negedge clk); mem_write = 0; mem_read = 1; mem_addr = 4; #2;
        checks++; if (err_addr !== 1'b1 || mem_rdata !== 32'h0C || mem_stall !== 1'b0) begin
            fails++; $display("FAIL err_set got=%b/%h/%b exp=1/0c/0 (no rec gap)", err_addr, mem_rdata, mem_stall); end
        @(negedge clk); #2;
        checks++; if (err_addr !== 1'b1) begin
            fails++; $display("FAIL err_sticky got=%b exp=1", err_addr); end
        rst = 1; idle_inputs(); #1;
        checks++; if (err_addr !== 1'b0) begin
            fails++; $display("FAIL err_rstclr got=%b exp=0", err_addr); end
        @(negedge clk); rst = 0; mem_read = 1; mem_write = 1; mem_addr = 4; #2;
        checks++; if ({dm_read, dm_write, mem_stall} !== 3'b0 || mem_rdata !== 32'd0) begin
            fails++; $display("FAIL err_illegal got=%b/%h exp=000/0", {dm_read, dm_write, mem_stall}, mem_rdata); end
        @(negedge clk); idle_inputs(); #2;
        checks++; if (err_addr !== 1'b1) begin
            fails++; $display("FAIL err_illegal_set got=%b exp=1", err_addr); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); mem_write = 1; mem_addr = 7; mem_wdata = 32'h77;
        dbg_req = 1; dbg_we = 0; dbg_addr = 4; #2;
        checks++; if (dm_write !== 1'b1 || dbg_gnt !== 1'b0) begin
            fails++; $display("FAIL rmid_c0 got=%b/%b exp=1/0", dm_write, dbg_gnt); end
        @(negedge clk); mem_write = 0; #2;
        checks++; if (dbg_gnt !== 1'b0 || dm_read !== 1'b0) begin
            fails++; $display("FAIL rmid_rec got=%b/%b exp=0/0", dbg_gnt, dm_read); end
        rst = 1; #1;
        checks++; if (err_addr !== 1'b0 || dbg_rvalid !== 1'b0 || dm_write !== 1'b0 || dbg_rdata !== 32'd0) begin
            fails++; $display("FAIL rmid_rst got=%b/%b/%b/%h exp=0/0/0/0", err_addr, dbg_rvalid, dm_write, dbg_rdata); end
        @(negedge clk); rst = 0; #2;
        checks++; if (dbg_gnt !== 1'b1 || dm_read !== 1'b1 || dm_addr !== 32'd4) begin
            fails++; $display("FAIL rmid_gnt got=%b/%b/%0d exp=1/1/4", dbg_gnt, dm_read, dm_addr); end
        @(negedge clk); dbg_req = 0; #2;
        checks++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'h0C) begin
            fails++; $display("FAIL rmid_ret got=%b/%h exp=1/0000000c", dbg_rvalid, dbg_rdata); end
        // a grant followed by reset must not produce a read return
        @(negedge clk); dbg_req = 1; dbg_addr = 5; #2;
        rst = 1; dbg_req = 0;
        @(negedge clk); #2;
        checks++; if (dbg_rvalid !== 1'b0 || dbg_rdata !== 32'd0) begin
            fails++; $display("FAIL rmid_drop got=%b/%h exp=0/0", dbg_rvalid, dbg_rdata); end
        rst = 0;
        @(negedge clk); #2;
        checks++; if (tb_mem[7] !== 32'h77) begin
            fails++; $display("FAIL rmid_wr7 got=%h exp=00000077", tb_mem[7]); end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) tb_mem[i] = 32'd0;
        tb_mem[4] = 32'h0000000C;
        test_reset();
        test_a_read();
        test_back_to_back();
        test_dbg_read();
        test_starve();
        test_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
